frame_rx: RTL and testbench

Serial-to-parallel frame receiver for the clocked serial link; the receiving end for a framed word-serial transmitter sharing the same clock. It detects a start bit, shifts in N_WORDS words of WORD_W bits, checks even parity and the stop bit, then loads the words into parallel output registers. It pulses received_n on a good frame and flags parity or framing errors otherwise.

---
 rtl/frame_rx.sv | 154 +++++++++++++++
 tb/tb_frame_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx.sv
// ============================================================================
// Module   : frame_rx
// Brief    : Serial-to-parallel frame receiver. Optional parity bit and
//            PARITY state are built when macro RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_rx #(
    parameter int WORD_W  = 4,
    parameter int N_WORDS = 4,
    parameter int BW      = (WORD_W  > 1) ? $clog2(WORD_W)  : 1,
    parameter int WW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        rx_en,
    input  logic                        data_in,
    output logic [N_WORDS*WORD_W-1:0]   words_out,
    output logic [BW-1:0]               Qbit,
    output logic [WW-1:0]               Qwrd,
    output logic                        busy,
    output logic                        received_n,
    output logic                        parity_err,
    output logic                        frame_err
);

    localparam int C_TOT = N_WORDS * WORD_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [C_TOT-1:0]     r_buf;
    logic [C_TOT-1:0]     r_words;
    logic [BW-1:0]        r_qbit;
    logic [WW-1:0]        r_qwrd;
    logic                 r_busy;
    logic                 r_rx_n;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_wait_high;
    logic                 w_bit_last;
    logic                 w_last;
    logic                 w_par_bad;

    assign w_bit_last = (r_qbit == BW'(WORD_W - 1));
    assign w_last     = w_bit_last && (r_qwrd == WW'(N_WORDS - 1));

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (!data_in && !r_wait_high) w_state_nx = S_DATA;
`ifdef RX_PARITY_EN
            S_DATA:   if (w_last) w_state_nx = S_PARITY;
`else
            S_DATA:   if (w_last) w_state_nx = S_STOP;
`endif
            S_PARITY: w_state_nx = S_STOP;
            S_STOP:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
        if (!rx_en) w_state_nx = S_IDLE;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

`ifdef RX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                          r_par <= 1'b0;
        else if (r_state == S_IDLE)                       r_par <= 1'b0;
        else if (r_state == S_DATA || r_state == S_PARITY) r_par <= r_par ^ data_in;
    end

    assign w_par_bad = r_par;
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_buf       <= '0;
            r_words     <= '0;
            r_qbit      <= '0;
            r_qwrd      <= '0;
            r_busy      <= 1'b0;
            r_rx_n      <= 1'b1;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_wait_high <= 1'b0;
        end else begin
            r_rx_n <= 1'b1;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_busy <= (w_state_nx != S_IDLE);
            // A zero stop bit leaves the line low; re-arm only once it is seen high.
            if (r_state == S_IDLE && data_in) r_wait_high <= 1'b0;
            if (!rx_en) begin
                r_qbit <= '0;
                r_qwrd <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_qbit <= '0;
                        r_qwrd <= '0;
                    end
                    S_DATA: begin
                        // LSB-first arrival: shifting down places bit i at index i.
                        r_buf <= {data_in, r_buf[C_TOT-1:1]};
                        if (w_bit_last) begin
                            r_qbit <= '0;
                            r_qwrd <= w_last ? '0 : r_qwrd + 1'b1;
                        end else begin
                            r_qbit <= r_qbit + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (!data_in) begin
                            r_ferr      <= 1'b1;
                            r_wait_high <= 1'b1;
                        end else if (w_par_bad) begin
                            r_perr <= 1'b1;
                        end else begin
                            r_words <= r_buf;
                            r_rx_n  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign words_out  = r_words;
    assign Qbit       = r_qbit;
    assign Qwrd       = r_qwrd;
    assign busy       = r_busy;
    assign received_n = r_rx_n;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_frame_rx.sv
// ============================================================================
// Module   : tb_frame_rx
// Brief    : Self-checking bench for frame_rx with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_rx;

    localparam int C_TOT = 16;
`ifdef RX_PARITY_EN
    localparam int C_HAS_PAR = 1;
`else
    localparam int C_HAS_PAR = 0;
`endif
    localparam int C_FLEN = C_TOT + 2 + C_HAS_PAR;

    typedef struct {
        int          kind;   // 0 good, 1 parity error, 2 frame error
        logic [15:0] words;
    } exp_t;

    logic        clk;
    logic        clr;
    logic        rx_en;
    logic        data_in;
    logic [15:0] words_out;
    logic [1:0]  Qbit;
    logic [1:0]  Qwrd;
    logic        busy;
    logic        received_n;
    logic        parity_err;
    logic        frame_err;

    int          errors;
    int          checks;
    int          cyc;
    int          last_pulse;
    logic [15:0] model_words;
    exp_t        sb[$];

    frame_rx dut (
        .clk        (clk),
        .clr        (clr),
        .rx_en      (rx_en),
        .data_in    (data_in),
        .words_out  (words_out),
        .Qbit       (Qbit),
        .Qwrd       (Qwrd),
        .busy       (busy),
        .received_n (received_n),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; pushes the expected result just before the stop edge.
    task automatic send_frame(input logic [15:0] w, input bit bad_par, input bit stop);
        exp_t e;
        logic p;
        p = (^w) ^ bad_par;
        data_in = 1'b0;
        tick();
        checks++;
        if (received_n !== 1'b1 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL start_quiet: rxn=%b perr=%b ferr=%b required 1 0 0", received_n, parity_err, frame_err);
        end
        for (int i = 0; i < C_TOT; i++) begin
            checks++;
            if (Qbit !== 2'(i % 4) || Qwrd !== 2'(i / 4) || busy !== 1'b1) begin
                errors++;
                $display("FAIL counters bit %0d: Qbit=%0d Qwrd=%0d busy=%b required %0d %0d 1",
                         i, Qbit, Qwrd, busy, i % 4, i / 4);
            end
            data_in = w[i];
            tick();
        end
        if (C_HAS_PAR != 0) begin
            data_in = p;
            tick();
        end
        checks++;
        if (received_n !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_pulse: rxn=%b busy=%b required 1 1", received_n, busy);
        end
        e.words = w;
        if (!stop)                      e.kind = 2;
        else if (bad_par && C_HAS_PAR != 0) e.kind = 1;
        else                            e.kind = 0;
        sb.push_back(e);
        data_in = stop;
        tick();
    endtask

    task automatic check_result();
        exp_t e;
        logic        exp_rxn;
        logic        exp_perr;
        logic        exp_ferr;
        e = sb.pop_front();
        exp_rxn  = (e.kind == 0) ? 1'b0 : 1'b1;
        exp_perr = (e.kind == 1);
        exp_ferr = (e.kind == 2);
        if (e.kind == 0) model_words = e.words;
        checks++;
        if (received_n !== exp_rxn || parity_err !== exp_perr || frame_err !== exp_ferr) begin
            errors++;
            $display("FAIL status kind %0d: rxn=%b perr=%b ferr=%b required %b %b %b",
                     e.kind, received_n, parity_err, frame_err, exp_rxn, exp_perr, exp_ferr);
        end
        checks++;
        if (words_out !== model_words) begin
            errors++;
            $display("FAIL words_out kind %0d: got %h required %h", e.kind, words_out, model_words);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_stop: got %b required 0", busy);
        end
        if (e.kind == 0) last_pulse = cyc;
    endtask

    task automatic test_reset();
        checks++;
        if (words_out !== 16'h0 || Qbit !== 2'd0 || Qwrd !== 2'd0 || busy !== 1'b0 ||
            received_n !== 1'b1 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: words=%h Qbit=%0d Qwrd=%0d busy=%b rxn=%b perr=%b ferr=%b required 0 0 0 0 1 0 0",
                     words_out, Qbit, Qwrd, busy, received_n, parity_err, frame_err);
        end
    endtask

    task automatic test_good();
        int start_cyc;
        start_cyc = cyc + 1;
        send_frame(16'hF5A3, 1'b0, 1'b1);
        check_result();
        checks++;
        if (cyc - start_cyc !== C_TOT + 1 + C_HAS_PAR) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", cyc - start_cyc, C_TOT + 1 + C_HAS_PAR);
        end
        data_in = 1'b1;
        tick();
        checks++;
        if (received_n !== 1'b1) begin
            errors++;
            $display("FAIL pulse_width: rxn=%b required 1", received_n);
        end
    endtask

    task automatic test_parity();
        send_frame(16'h0C96, 1'b1, 1'b1);
        check_result();
        data_in = 1'b1;
        tick();
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_width: got %b required 0", parity_err);
        end
    endtask

    task automatic test_frame_err();
        send_frame(16'h7E81, 1'b0, 1'b0);
        check_result();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL held_low %0d: busy=%b ferr=%b required 0 0", k, busy, frame_err);
            end
        end
        data_in = 1'b1;
        tick();
        send_frame(16'h4C1D, 1'b0, 1'b1);
        check_result();
        data_in = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int first;
        send_frame(16'hF5A3, 1'b0, 1'b1);
        check_result();
        first = last_pulse;
        send_frame(16'h1234, 1'b0, 1'b1);
        check_result();
        checks++;
        if (last_pulse - first !== C_FLEN) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required %0d", last_pulse - first, C_FLEN);
        end
        data_in = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        data_in = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            data_in = i[0];
            tick();
        end
        rx_en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || Qbit !== 2'd0 || Qwrd !== 2'd0 || received_n !== 1'b1 ||
            words_out !== model_words) begin
            errors++;
            $display("FAIL abort: busy=%b Qbit=%0d Qwrd=%0d rxn=%b words=%h required 0 0 0 1 %h",
                     busy, Qbit, Qwrd, received_n, words_out, model_words);
        end
        rx_en   = 1'b1;
        data_in = 1'b1;
        tick();
        data_in = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            data_in = 1'b1;
            tick();
        end
        clr = 1'b1;
        #1;
        model_words = 16'h0;
        test_reset();
        tick();
        clr     = 1'b0;
        data_in = 1'b1;
        tick();
        send_frame(16'hBEEF, 1'b0, 1'b1);
        check_result();
        data_in = 1'b1;
        tick();
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        last_pulse  = 0;
        model_words = 16'h0;
        clr         = 1'b1;
        rx_en       = 1'b0;
        data_in     = 1'b1;
        #3;
        test_reset();
        tick();
        tick();
        clr   = 1'b0;
        rx_en = 1'b1;
        tick();
        test_good();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
